power_iter_ctrl: RTL

- Sequencer for the power-iteration eigen-solver datapath. Drives three shared units in order, repeating until convergence or an iteration limit:
  - mat-vec multiply (v' = A·v)
  - vector normalise
  - eigenvalue (Rayleigh quotient vᵀ·A·v)
- Latches the final double eigenvalue and iteration count, then signals completion to the upstream fetal-ECG separation stage.

---
 rtl/power_iter_ctrl_if.sv | 32 +++
 rtl/power_iter_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/power_iter_ctrl_if.sv
// power_iter_ctrl_if: handshake/result bundle between the power-iteration sequencer and its datapath
// master: sequencer side (drives starts and results, samples go/abort/valids/converged)
// slave:  datapath/upstream side (the reverse direction)
interface power_iter_ctrl_if #(
    parameter int ITER_W = 6
);
    logic              go;
    logic              abort;
    logic              mv_start;
    logic              mv_valid;
    logic              nrm_start;
    logic              nrm_valid;
    logic              eig_start;
    logic              eig_valid;
    logic [63:0]       eigenvalue_in;
    logic              converged;
    logic [63:0]       eigenvalue;
    logic [ITER_W-1:0] iter_count;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  go, abort, mv_valid, nrm_valid, eig_valid, eigenvalue_in, converged,
        output mv_start, nrm_start, eig_start, eigenvalue, iter_count, busy, done, err
    );

    modport slave (
        output go, abort, mv_valid, nrm_valid, eig_valid, eigenvalue_in, converged,
        input  mv_start, nrm_start, eig_start, eigenvalue, iter_count, busy, done, err
    );
endinterface

// File: rtl/power_iter_ctrl.sv
// power_iter_ctrl: sequences mat-vec, normalise and eigenvalue units until convergence or MAX_ITER
// Ports: clk; rst (asynchronous, active-high);
//   bus (power_iter_ctrl_if.master): go/abort requests, mv/nrm/eig start-valid handshakes,
//   eigenvalue_in and converged from the datapath, registered eigenvalue/iter_count/busy/done/err.
// Optional: define POWER_ITER_WATCHDOG_EN for a per-stage STAGE_TIMEOUT watchdog (TOUT state, sticky err).
module power_iter_ctrl #(
    parameter int SIZE_N        = 8,
    parameter int MAX_ITER      = 32,
    parameter int ITER_W        = 6,
    parameter int STAGE_TIMEOUT = 1024
) (
    input logic               clk,
    input logic               rst,
    power_iter_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, MV, NRM, EIG, CHECK, DONE, TOUT} state_t;

    if (SIZE_N < 1 || MAX_ITER < 1 || MAX_ITER >= (1 << ITER_W) || STAGE_TIMEOUT < 1) begin : g_bad_cfg
        $error("power_iter_ctrl: invalid parameter set");
    end

    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    state_t            state_q, state_d;
    logic [2:0]        start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [63:0]       last_eig_q, last_eig_d;
    logic [63:0]       eig_q, eig_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              stage_valid;
    logic              timeout;

    always_comb begin
        state_d     = state_q;
        last_eig_d  = last_eig_q;
        iter_d      = iter_q;
        eig_d       = eig_q;
        // only the unit whose start is currently asserted is listened to
        stage_valid = (state_q == MV)  ? bus.mv_valid  :
                      (state_q == NRM) ? bus.nrm_valid :
                      (state_q == EIG) ? bus.eig_valid : 1'b0;
        case (state_q)
            IDLE:  if (bus.go) begin
                       state_d = MV;
                       iter_d  = '0;
                   end
            MV:    if (stage_valid) state_d = NRM;
            NRM:   if (stage_valid) state_d = EIG;
            EIG:   if (stage_valid) begin
                       state_d    = CHECK;
                       last_eig_d = bus.eigenvalue_in;
                       iter_d     = (iter_q == ITER_MAX) ? iter_q : iter_q + 1'b1;
                   end
            CHECK: state_d = (bus.converged || iter_q == ITER_MAX) ? DONE : MV;
            default: state_d = IDLE;
        endcase
        if (timeout && !stage_valid) state_d = TOUT;
        // abort beats valid and the CHECK decision; discard any latch of this cycle
        if (bus.abort && state_q != IDLE) begin
            state_d    = IDLE;
            last_eig_d = last_eig_q;
            iter_d     = iter_q;
        end
        if (state_d == DONE) eig_d = last_eig_q;
        start_d = {state_d == EIG, state_d == NRM, state_d == MV};
        busy_d  = state_d != IDLE && state_d != DONE;
        done_d  = state_d == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            start_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            last_eig_q <= '0;
            eig_q      <= '0;
            iter_q     <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            last_eig_q <= last_eig_d;
            eig_q      <= eig_d;
            iter_q     <= iter_d;
        end
    end

`ifdef POWER_ITER_WATCHDOG_EN
    localparam int WD_W = $clog2(STAGE_TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            in_stage;

    assign in_stage = state_q == MV || state_q == NRM || state_q == EIG;
    assign timeout  = in_stage && wd_q == WD_W'(STAGE_TIMEOUT - 1);

    always_comb begin
        // restarts from zero on every stage entry, counts only while still waiting
        wd_d  = (in_stage && state_d == state_q) ? wd_q + 1'b1 : '0;
        err_d = (state_q == IDLE && bus.go) ? 1'b0 : (state_d == TOUT) ? 1'b1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout = 1'b0;
    assign bus.err = 1'b0;
`endif

    assign bus.mv_start   = start_q[0];
    assign bus.nrm_start  = start_q[1];
    assign bus.eig_start  = start_q[2];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.eigenvalue = eig_q;
    assign bus.iter_count = iter_q;
endmodule
